// File: rtl/fetch_buffered_stage_pkg.sv
// Shared constants for the buffered instruction-fetch stage.
package fetch_buffered_stage_pkg;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

   // Sequential fetch stride in bytes.
   localparam int unsigned INSTRUCTION_BYTES = 4;

   // Base RV32 major opcodes, for decode-side consumers of the stage.
   typedef enum logic [6:0] {
      OpLoad   = 7'h03,
      OpMiscMem = 7'h0f,
      OpOpImm  = 7'h13,
      OpAuipc  = 7'h17,
      OpStore  = 7'h23,
      OpOp     = 7'h33,
      OpLui    = 7'h37,
      OpBranch = 7'h63,
      OpJalr   = 7'h67,
      OpJal    = 7'h6f,
      OpSystem = 7'h73
   } rv_opcode_e;

endpackage

// File: rtl/fetch_buffered_stage_if.sv
// Handshake bundle between the fetch stage, instruction memory and decode.
// master: the fetch stage. slave: memory/decode/branch environment.
interface fetch_buffered_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_address;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_address;
   logic            imem_resp_valid;
   logic [31:0]     imem_resp_data;
   logic            decode_ready;
   logic            decode_valid;
   logic [31:0]     instruction_register;
   logic [XLEN-1:0] current_program_counter;
   logic [XLEN-1:0] next_program_counter;

   modport master (
      input  redirect_valid, redirect_address, imem_req_ready, imem_resp_valid, imem_resp_data,
             decode_ready,
      output imem_req_valid, imem_req_address, decode_valid, instruction_register,
             current_program_counter, next_program_counter
   );

   modport slave (
      output redirect_valid, redirect_address, imem_req_ready, imem_resp_valid, imem_resp_data,
             decode_ready,
      input  imem_req_valid, imem_req_address, decode_valid, instruction_register,
             current_program_counter, next_program_counter
   );
endinterface

// File: rtl/fetch_instruction_queue.sv
// Synchronous FIFO of {pc, instruction} pairs with a show-ahead head and flush.
module fetch_instruction_queue #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned Depth = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [XLEN-1:0]            push_pc_i,
   input  logic [31:0]                push_instr_i,
   input  logic                       pop_i,
   output logic [$clog2(Depth):0]     count_o,
   output logic                       empty_o,
   output logic [XLEN-1:0]            head_pc_o,
   output logic [31:0]                head_instr_o
);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [XLEN-1:0] pc_mem_q    [Depth];
   logic [31:0]     instr_mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   // Pointer/count update; flush wins over push and pop, pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CntW'(push_i) - CntW'(pop_i);
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only meaningful while counted, so no reset.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) begin
         pc_mem_q[wr_ptr_q]    <= push_pc_i;
         instr_mem_q[wr_ptr_q] <= push_instr_i;
      end
   end

   assign count_o      = count_q;
   assign empty_o      = (count_q == '0);
   assign head_pc_o    = pc_mem_q[rd_ptr_q];
   assign head_instr_o = instr_mem_q[rd_ptr_q];

   // Credit logic upstream must never push into a full queue.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      (push_i && !flush_i) |-> (count_q != CntW'(Depth)));

endmodule

// File: rtl/fetch_buffered_stage.sv
// Instruction-fetch stage: issues sequential PC requests against a credit of
// QUEUE_DEPTH, buffers in-order responses, and on redirect flushes the queue and
// drops responses still in flight for the old path.
module fetch_buffered_stage #(
   parameter int unsigned     XLEN                    = 32,
   parameter logic [XLEN-1:0] INITIAL_PROGRAM_COUNTER = 'h1000,
   parameter int unsigned     QUEUE_DEPTH             = 4,
   parameter logic [31:0]     NOP_INSTRUCTION         = fetch_buffered_stage_pkg::NOP_INSTRUCTION
) (
   input logic                    clk,
   input logic                    reset,
   fetch_buffered_stage_if.master bus
);
   import fetch_buffered_stage_pkg::*;

   localparam int unsigned     CntW      = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CntW:0]   CreditMax = (CntW + 1)'(QUEUE_DEPTH);
   localparam logic [XLEN-1:0] PcStep    = XLEN'(INSTRUCTION_BYTES);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CntW-1:0] inflight_q, inflight_d;
   logic [CntW-1:0] drop_q, drop_d;

   logic [CntW-1:0] q_count;
   logic            q_empty;
   logic [XLEN-1:0] head_pc;
   logic [31:0]     head_instr;
   logic [CntW:0]   credit_used;
   logic            req_fire;
   logic            resp_keep;
   logic            q_pop;
   logic [XLEN-1:0] cur_pc;

   // Buffered plus outstanding entries may never exceed the queue size.
   assign credit_used        = {1'b0, q_count} + {1'b0, inflight_q};
   assign bus.imem_req_valid   = !bus.redirect_valid && (credit_used < CreditMax);
   assign bus.imem_req_address = fetch_pc_q;

   assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
   assign resp_keep = bus.imem_resp_valid && (drop_q == '0) && !bus.redirect_valid;
   assign q_pop     = !q_empty && bus.decode_ready && !bus.redirect_valid;

   // Next-state for PCs and counters; redirect overrides everything else.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      drop_d     = drop_q;
      inflight_d = inflight_q + CntW'(req_fire) - CntW'(bus.imem_resp_valid);
      if (req_fire)  fetch_pc_d = fetch_pc_q + PcStep;
      if (resp_keep) resp_pc_d  = resp_pc_q + PcStep;
      if (bus.imem_resp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_address;
         resp_pc_d  = bus.redirect_address;
         // A response landing in the redirect cycle is discarded right here.
         drop_d     = inflight_q - CntW'(bus.imem_resp_valid);
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= INITIAL_PROGRAM_COUNTER;
         resp_pc_q  <= INITIAL_PROGRAM_COUNTER;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   fetch_instruction_queue #(
      .XLEN  (XLEN),
      .Depth (QUEUE_DEPTH)
   ) u_queue (
      .clk_i        (clk),
      .rst_i        (reset),
      .flush_i      (bus.redirect_valid),
      .push_i       (resp_keep),
      .push_pc_i    (resp_pc_q),
      .push_instr_i (bus.imem_resp_data),
      .pop_i        (q_pop),
      .count_o      (q_count),
      .empty_o      (q_empty),
      .head_pc_o    (head_pc),
      .head_instr_o (head_instr)
   );

   // Decode view comes purely from queue state; an empty queue shows a NOP at
   // the PC the next kept response will carry.
   always_comb begin
      cur_pc                      = q_empty ? resp_pc_q : head_pc;
      bus.decode_valid            = !q_empty;
      bus.instruction_register    = q_empty ? NOP_INSTRUCTION : head_instr;
      bus.current_program_counter = cur_pc;
      bus.next_program_counter    = cur_pc + PcStep;
   end

   // Memory answers only requests it accepted, so a response implies credit.
   a_resp_has_credit: assert property (@(posedge clk) disable iff (reset)
      bus.imem_resp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fetch_buffered_stage.sv
// Scoreboarded bench for fetch_buffered_stage: a memory model answers accepted
// requests in order after a chosen latency, stimulus pushes the PCs decode
// should see, and a monitor checks every pop against that queue.
module tb_fetch_buffered_stage;
   localparam int unsigned XLEN = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fetch_buffered_stage_if #(.XLEN(XLEN)) bus ();

   fetch_buffered_stage #(
      .XLEN                    (XLEN),
      .INITIAL_PROGRAM_COUNTER (32'h1000),
      .QUEUE_DEPTH             (4),
      .NOP_INSTRUCTION         (32'h13)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic [31:0] exp_q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   bit          ready_rand = 1'b0;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          stall_prev = 1'b0;
   logic [31:0] stall_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5a5a, a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Instruction memory model: drives at negedge, samples 1 time unit before posedge.
   initial begin
      pend_t p;
      bus.imem_req_ready  = 1'b1;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         bus.imem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         if (pend.size() != 0 && pend[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
         end
         #4;
         if (reset) begin
            pend.delete();
            stall_prev = 1'b0;
         end else begin
            if (stall_prev && !bus.redirect_valid) begin
               chk("req_hold_valid", {31'b0, bus.imem_req_valid}, 32'd1);
               chk("req_hold_addr", bus.imem_req_address, stall_addr);
            end
            stall_prev = bus.imem_req_valid && !bus.imem_req_ready;
            stall_addr = bus.imem_req_address;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
               p.addr = bus.imem_req_address;
               p.due  = cyc + int'($urandom_range(lat_min, lat_max));
               pend.push_back(p);
            end
         end
      end
   end

   // Scoreboard monitor: every accepted pop is compared against the expected queue.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         #4;
         if (!reset && bus.decode_valid && bus.decode_ready && !bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_pop: got pc %h expected no pop", bus.current_program_counter);
            end else begin
               e = exp_q.pop_front();
               chk("pop_pc", bus.current_program_counter, e);
               chk("pop_instr", bus.instruction_register, mem_word(e));
               chk("pop_next_pc", bus.next_program_counter, e + 32'd4);
            end
         end
      end
   end

   // Called at a negedge; leaves reset low at a negedge.
   task automatic do_reset();
      reset = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.decode_ready   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic push_seq(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
   endtask

   // Called at a negedge; holds decode_ready until the scoreboard empties.
   task automatic drain(input int budget, input bit rnd, output int used);
      used = 0;
      while (exp_q.size() != 0 && used < budget) begin
         bus.decode_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         used++;
      end
      bus.decode_ready = 1'b0;
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int used;
      bus.redirect_valid   = 1'b0;
      bus.redirect_address = '0;
      bus.decode_ready     = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #4;
      chk("rst_decode_valid", {31'b0, bus.decode_valid}, 32'd0);
      chk("rst_instr", bus.instruction_register, 32'h13);
      chk("rst_cur_pc", bus.current_program_counter, 32'h1000);
      chk("rst_next_pc", bus.next_program_counter, 32'h1004);
      @(negedge clk);
      reset = 1'b0;
      #4;
      chk("first_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
      chk("first_req_addr", bus.imem_req_address, 32'h1000);

      // 1: latency 1, first instruction visible two cycles after the first accept
      @(negedge clk);
      #4;
      chk("lat_valid_early", {31'b0, bus.decode_valid}, 32'd0);
      @(negedge clk);
      #4;
      chk("lat_valid_on", {31'b0, bus.decode_valid}, 32'd1);
      chk("lat_head_instr", bus.instruction_register, mem_word(32'h1000));
      @(negedge clk);
      push_seq(32'h1000, 12);
      drain(100, 1'b0, used);
      chk("stream_no_gaps", 32'(used), 32'd12);

      // 2: decode stall fills the queue and stops requests
      repeat (10) @(negedge clk);
      #4;
      chk("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
      chk("stall_decode_valid", {31'b0, bus.decode_valid}, 32'd1);
      chk("stall_head_pc", bus.current_program_counter, 32'h1030);
      @(negedge clk);
      push_seq(32'h1030, 8);
      drain(100, 1'b0, used);
      chk("release_no_gaps", 32'(used), 32'd8);

      // 3: redirect with three requests in flight at latency 4
      do_reset();
      lat_min = 4;
      lat_max = 4;
      repeat (3) @(negedge clk);
      bus.redirect_valid   = 1'b1;
      bus.redirect_address = 32'h2000;
      #4;
      chk("redir_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      #4;
      chk("redir_empty", {31'b0, bus.decode_valid}, 32'd0);
      chk("redir_req_addr", bus.imem_req_address, 32'h2000);
      @(negedge clk);
      push_seq(32'h2000, 8);
      drain(200, 1'b0, used);

      // 4: redirect coincides with a response and a pop attempt (latency 2)
      do_reset();
      lat_min = 2;
      lat_max = 2;
      bus.decode_ready = 1'b1;
      repeat (3) @(negedge clk);
      bus.redirect_valid   = 1'b1;
      bus.redirect_address = 32'h3000;
      #4;
      chk("same_cycle_head_valid", {31'b0, bus.decode_valid}, 32'd1);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      #4;
      chk("same_cycle_flushed", {31'b0, bus.decode_valid}, 32'd0);
      chk("same_cycle_nop", bus.instruction_register, 32'h13);
      chk("same_cycle_req_addr", bus.imem_req_address, 32'h3000);
      @(negedge clk);
      push_seq(32'h3000, 8);
      drain(200, 1'b0, used);

      // 5: random memory ready, latency 1..5 and decode ready
      do_reset();
      lat_min    = 1;
      lat_max    = 5;
      ready_rand = 1'b1;
      push_seq(32'h1000, 40);
      drain(3000, 1'b1, used);
      ready_rand = 1'b0;
      lat_min    = 1;
      lat_max    = 1;

      // 6: reset with a full queue
      repeat (12) @(negedge clk);
      #4;
      chk("full_decode_valid", {31'b0, bus.decode_valid}, 32'd1);
      chk("full_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #4;
      chk("midrst_decode_valid", {31'b0, bus.decode_valid}, 32'd0);
      chk("midrst_instr", bus.instruction_register, 32'h13);
      chk("midrst_cur_pc", bus.current_program_counter, 32'h1000);
      @(negedge clk);
      reset = 1'b0;
      #4;
      chk("midrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
      chk("midrst_req_addr", bus.imem_req_address, 32'h1000);
      @(negedge clk);
      push_seq(32'h1000, 6);
      drain(100, 1'b0, used);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
